// File: rtl/nv_nvdla_cvif_cfg_master_if.sv
// Command/response handshake bundle between a CSB requester
// and the CVIF config master.
interface nv_nvdla_cvif_cfg_master_if #(
  parameter int ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr,
    output cmd_wdata, cmd_be, rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr,
    input  cmd_wdata, cmd_be, rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/nv_nvdla_cvif_cfg_master.sv
// CSB-side initiator into the CVIF register file (byte writes by RMW).
// Optional write readback check: define CVIF_CFG_MASTER_RDBK_EN.
module nv_nvdla_cvif_cfg_master #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 12
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  nv_nvdla_cvif_cfg_master_if.slave bus,
  output logic [ADDR_W-1:0]    reg_offset,
  output logic [31:0]          reg_wr_data,
  output logic                 reg_wr_en,
  input  logic [31:0]          reg_rd_data,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR      = 3'd2,
`ifdef CVIF_CFG_MASTER_RDBK_EN
    VFY     = 3'd3,
`endif
    RSP     = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t      state;
  state_t      nxt;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic accept;
  logic mis;
  logic full;
  logic last;

  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign mis    = |bus.cmd_addr[1:0];
  assign full   = bus.cmd_wr & (bus.cmd_be == 4'hF);
  assign last   = (cnt == 4'd0);

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (mis)       nxt = RSP;
          else if (full) nxt = WR;
          else           nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (last) nxt = wr_q ? WR : RSP;
      end
`ifdef CVIF_CFG_MASTER_RDBK_EN
      WR:  nxt = VFY;
      VFY: if (last) nxt = RSP;
`else
      WR:  nxt = RSP;
`endif
      RSP: if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are gated by reset so an in-flight write never fires.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    reg_wr_en     = 1'b0;
    if (!nvdla_core_rst) begin
      unique case (state)
        IDLE:    bus.cmd_ready = 1'b1;
        WR:      reg_wr_en     = 1'b1;
        RSP:     bus.rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt           <= 4'd0;
      wr_q          <= 1'b0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      reg_offset    <= '0;
      reg_wr_data   <= 32'd0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      err_cnt       <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= bus.cmd_wr;
            be_q    <= bus.cmd_be;
            wdata_q <= bus.cmd_wdata;
            cnt     <= LAT_M1;
            if (mis) begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'd0;
            end else begin
              bus.rsp_err <= 1'b0;
              reg_offset  <= bus.cmd_addr;
              if (full) reg_wr_data <= bus.cmd_wdata;
            end
          end
        end
        RD_WAIT: begin
          if (!last) begin
            cnt <= cnt - 4'd1;
          end else if (wr_q) begin
            reg_wr_data <= (wdata_q & be_mask(be_q))
                         | (reg_rd_data & ~be_mask(be_q));
          end else begin
            bus.rsp_rdata <= reg_rd_data;
          end
        end
        WR: begin
          bus.rsp_rdata <= reg_wr_data;
          cnt           <= LAT_M1;
        end
`ifdef CVIF_CFG_MASTER_RDBK_EN
        VFY: begin
          if (!last) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.rsp_rdata <= reg_rd_data;
            bus.rsp_err   <= |((reg_rd_data ^ reg_wr_data)
                               & be_mask(be_q));
          end
        end
`endif
        RSP: begin
          if (bus.rsp_ready && bus.rsp_err
              && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
